instr_fetch_unit: RTL

// Instruction fetch stage. Drives the instruction-segment address port (a1) of the segmented memory.

---
 rtl/instr_fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage for the segmented memory. Drives the instruction
// address port, captures the returned instruction one cycle later into a
// small prefetch FIFO and presents the FIFO head to decode over a
// valid/ready handshake. A branch redirect flushes queued and in-flight
// fetches and restarts fetch at the branch target.
//
// Optional feature: define IFU_PERF_CNT_EN to build the fetch/redirect
// performance counters; otherwise both counter ports read 0.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   imem_addr      instruction address to memory port a1 (always the fetch pc)
//   imem_rdata     instruction from memory rd1, valid one cycle after address
//   redirect       branch taken, restart fetch at redirect_pc
//   redirect_pc    branch target
//   halt           stop issuing new fetches, queued entries still drain
//   dec_ready      decode accepts the presented instruction this cycle
//   dec_valid      dec_instr/dec_pc valid
//   dec_instr      FIFO head instruction
//   dec_pc         pc of dec_instr
//   fetch_count    FIFO pushes (perf counter)
//   redirect_count cycles with redirect asserted (perf counter)
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | first cycle after reset, nothing issued
// ST_RUN       | normal sequential fetch
// ST_REDIRECT  | cycle after a redirect, fetch restarts at the new pc
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int               WIDTH            = 32,
    parameter int               INSTRUCTIONWIDTH = 24,
    parameter int               FIFO_DEPTH       = 2,
    parameter int               PC_STEP          = 1,
    parameter logic [WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_pc,
    input  logic                        halt,
    input  logic                        dec_ready,
    output logic                        dec_valid,
    output logic [INSTRUCTIONWIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0]            dec_pc,
    output logic [31:0]                 fetch_count,
    output logic [31:0]                 redirect_count
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t                      state;
    logic [WIDTH-1:0]            pc;
    logic [WIDTH-1:0]            inflight_pc;
    logic                        inflight;
    logic [INSTRUCTIONWIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [WIDTH-1:0]            fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W:0]              count;

    logic                        redirect_act;
    logic                        pop;
    logic                        push;
    logic                        issue;
    logic [PTR_W:0]              occ;

    // Redirect is ignored in IDLE; nothing is in flight or queued there.
    assign redirect_act = redirect && (state != ST_IDLE);
    assign pop          = (count != '0) && dec_ready;
    assign push         = inflight && !redirect_act;

    // Occupancy counts the slot freed by this cycle's pop, so a full-rate
    // stream keeps one fetch per cycle while still reserving a slot for
    // every outstanding response.
    assign occ   = count - {{PTR_W{1'b0}}, pop} + {{PTR_W{1'b0}}, inflight};
    assign issue = (state != ST_IDLE) && !halt && !redirect && (occ < DEPTH_L);

    assign imem_addr = pc;
    assign dec_valid = (count != '0);
    assign dec_instr = fifo_instr[rd_ptr];
    assign dec_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            case (state)
                ST_IDLE:     state <= ST_RUN;
                ST_RUN:      state <= redirect ? ST_REDIRECT : ST_RUN;
                ST_REDIRECT: state <= redirect ? ST_REDIRECT : ST_RUN;
                default:     state <= ST_IDLE;
            endcase

            if (redirect_act) begin
                // A coincident pop needs no action: decode already took the head.
                pc       <= redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= pc;
                    pc          <= pc + WIDTH'(PC_STEP);
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`else
    assign fetch_count    = 32'd0;
    assign redirect_count = 32'd0;
`endif

endmodule
